// File: rtl/a2d_sched_pkg.sv
// a2d_sched_pkg: FSM state type and default sizing constants for the A2D scheduler
package a2d_sched_pkg;
   localparam int DEF_NUM_REQ = 3;
   localparam int DEF_RES_W   = 12;
   localparam int DEF_TMO_CYC = 1023;
   typedef enum logic [1:0] {IDLE, START, CONV, DONE} state_t;
endpackage

// File: rtl/a2d_sched_rr_arb.sv
// rr_arb: round-robin arbiter holding the last-granted pointer; search begins at last+1
module rr_arb
   import a2d_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               upd,
   input  logic [2:0]         upd_idx,
   output logic [NUM_REQ-1:0] win,
   output logic [2:0]         win_idx
);
   logic [2:0] last_q, last_d;
   logic       found;
   int         j;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 3'(NUM_REQ-1);
      else        last_q <= last_d;
   end
   always_comb begin
      last_d  = upd ? upd_idx : last_q;
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         j = int'(last_q) + i;
         j = (j >= NUM_REQ) ? j - NUM_REQ : j;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && k == j && req[k]) begin
               found   = 1'b1;
               win[k]  = 1'b1;
               win_idx = 3'(k);
            end
         end
      end
   end
endmodule

// File: rtl/a2d_sched.sv
// a2d_sched: shares one A2D among NUM_REQ requesters (IDLE/START/CONV/DONE FSM).
// Optional conversion watchdog enabled by macro A2D_TIMEOUT_EN.
module a2d_sched
   import a2d_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int RES_W   = DEF_RES_W,
   parameter int TMO_CYC = DEF_TMO_CYC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [NUM_REQ-1:0] done,
   output logic [RES_W-1:0]   res,
   output logic [2:0]         chnnl,
   output logic               strt,
   input  logic               cmplt,
   input  logic [RES_W-1:0]   a2d_res,
   output logic               busy,
   output logic               err
);
   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d, win;
   logic [2:0]         chnnl_q, chnnl_d, win_idx;
   logic [RES_W-1:0]   res_q, res_d;
   logic               tmo_hit;
   rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .upd     (state_q == DONE),
      .upd_idx (chnnl_q),
      .win     (win),
      .win_idx (win_idx)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         chnnl_q <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         chnnl_q <= chnnl_d;
         res_q   <= res_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = (|req) ? START : IDLE;
         START:   state_d = CONV;
         CONV:    state_d = (cmplt || tmo_hit) ? DONE : CONV;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      gnt_d   = (state_q == DONE) ? '0 : gnt_q;
      chnnl_d = chnnl_q;
      if (state_q == IDLE && |req) begin
         gnt_d   = win;
         chnnl_d = win_idx;
      end
      res_d = (state_q == CONV && cmplt) ? a2d_res : res_q;
   end
`ifdef A2D_TIMEOUT_EN
   localparam int CW = $clog2(TMO_CYC + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_q, tmo_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end
   // cmplt in the final watchdog cycle wins over the abort
   always_comb begin
      tmo_hit = (state_q == CONV) && (cnt_q == CW'(TMO_CYC - 1));
      tmo_d   = tmo_hit && !cmplt;
      cnt_d   = (state_q == CONV) ? cnt_q + CW'(1) : '0;
   end
   assign err = (state_q == DONE) && tmo_q;
`else
   logic unused_tmo;
   assign unused_tmo = |TMO_CYC;
   assign tmo_hit    = 1'b0;
   assign err        = 1'b0;
`endif
   always_comb begin
      strt  = (state_q == START);
      busy  = (state_q != IDLE);
      done  = (state_q == DONE) ? gnt_q : '0;
      gnt   = gnt_q;
      chnnl = chnnl_q;
      res   = res_q;
   end
endmodule

// File: tb/tb_a2d_sched.sv
// tb_a2d_sched: directed self-checking bench for a2d_sched (NUM_REQ=3, RES_W=12, TMO_CYC=16)
module tb_a2d_sched;
   logic        clk, rst_n, cmplt, strt, busy, err;
   logic [2:0]  req, gnt, done, chnnl;
   logic [11:0] res, a2d_res;
   int          errs = 0;
   int          checks = 0;

   a2d_sched #(.NUM_REQ(3), .RES_W(12), .TMO_CYC(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .done    (done),
      .res     (res),
      .chnnl   (chnnl),
      .strt    (strt),
      .cmplt   (cmplt),
      .a2d_res (a2d_res),
      .busy    (busy),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // one full conversion starting from IDLE with req already driven
   task automatic conv(input logic [2:0] eg, input logic [2:0] ech, input logic [11:0] val);
      tick();
      chk("cv_gnt", gnt, eg);
      chk("cv_chnnl", chnnl, ech);
      chk("cv_strt", strt, 1);
      tick();
      chk("cv_strt_low", strt, 0);
      tick();
      cmplt = 1'b1;
      a2d_res = val;
      tick();
      cmplt = 1'b0;
      chk("cv_done", done, eg);
      chk("cv_res", res, val);
      chk("cv_err", err, 0);
      tick();
      chk("cv_idle_busy", busy, 0);
      chk("cv_idle_gnt", gnt, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      req = '0;
      cmplt = 1'b0;
      a2d_res = '0;
      tick();
      tick();
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_res", res, 0);
      chk("rst_chnnl", chnnl, 0);
      chk("rst_strt", strt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;

      // single request, cmplt 20 clocks after strt
      req = 3'b010;
      tick();
      chk("s_gnt", gnt, 3'b010);
      chk("s_chnnl", chnnl, 1);
      chk("s_strt", strt, 1);
      chk("s_busy", busy, 1);
      tick();
      chk("s_strt_pulse", strt, 0);
      repeat (19) tick();
      chk("s_wait_busy", busy, 1);
      chk("s_wait_done", done, 0);
      cmplt = 1'b1;
      a2d_res = 12'hA5C;
      tick();
      chk("s_done", done, 3'b010);
      chk("s_res", res, 12'hA5C);
      chk("s_gnt_held", gnt, 3'b010);
      cmplt = 1'b0;
      req = '0;
      tick();
      chk("s_done_pulse", done, 0);
      chk("s_gnt_clr", gnt, 0);
      chk("s_idle", busy, 0);
      chk("s_res_hold", res, 12'hA5C);
      cmplt = 1'b1;
      a2d_res = 12'h123;
      tick();
      cmplt = 1'b0;
      chk("stray_res", res, 12'hA5C);
      chk("stray_busy", busy, 0);
      chk("stray_done", done, 0);

      // contention after reset: 0,1,2,0
      do_reset();
      req = 3'b111;
      conv(3'b001, 3'd0, 12'h111);
      conv(3'b010, 3'd1, 12'h222);
      conv(3'b100, 3'd2, 12'h333);
      conv(3'b001, 3'd0, 12'h444);

      // wrap from last grant 2
      req = 3'b100;
      conv(3'b100, 3'd2, 12'h555);
      req = 3'b101;
      conv(3'b001, 3'd0, 12'h666);
      conv(3'b100, 3'd2, 12'h777);
      req = '0;

      // request withdrawn during CONV
      req = 3'b001;
      tick();
      chk("w_gnt", gnt, 3'b001);
      tick();
      req = '0;
      tick();
      cmplt = 1'b1;
      a2d_res = 12'h3C7;
      tick();
      cmplt = 1'b0;
      chk("w_done", done, 3'b001);
      chk("w_res", res, 12'h3C7);
      tick();
      chk("w_idle", busy, 0);

      // reset during CONV, stray cmplt afterwards
      req = 3'b100;
      tick();
      tick();
      chk("r_conv_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req = '0;
      chk("r_gnt", gnt, 0);
      chk("r_done", done, 0);
      chk("r_res", res, 0);
      chk("r_chnnl", chnnl, 0);
      chk("r_strt", strt, 0);
      chk("r_busy", busy, 0);
      chk("r_err", err, 0);
      cmplt = 1'b1;
      a2d_res = 12'hFFF;
      tick();
      cmplt = 1'b0;
      chk("r_stray_done", done, 0);
      chk("r_stray_res", res, 0);
      chk("r_stray_busy", busy, 0);
      tick();
      chk("r_after_done", done, 0);

      // watchdog
      req = 3'b001;
      tick();
      tick();
      req = '0;
      chk("t_conv_busy", busy, 1);
`ifdef A2D_TIMEOUT_EN
      repeat (15) tick();
      chk("t_pre_err", err, 0);
      chk("t_pre_busy", busy, 1);
      chk("t_pre_done", done, 0);
      tick();
      chk("t_err", err, 1);
      chk("t_done", done, 3'b001);
      chk("t_res", res, 0);
      tick();
      chk("t_err_pulse", err, 0);
      chk("t_idle", busy, 0);
`else
      repeat (40) tick();
      chk("t_no_err", err, 0);
      chk("t_still_busy", busy, 1);
      chk("t_no_done", done, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
